// File: rtl/aes_core_arbiter_if.sv
// ----------------------------------------------------------------------------
// aes_core_arbiter_if : requester/core handshake bundle for aes_core_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface aes_core_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic             core_start;
  logic             core_done;
  logic [SEL_W-1:0] owner;
  logic [N_REQ-1:0] done_valid;
  logic             busy;
  logic             timeout_err;

  // master = arbiter side, slave = requesters plus encryption core
  modport master (
    input  req_valid, core_done,
    output req_ready, core_start, owner, done_valid, busy, timeout_err
  );

  modport slave (
    output req_valid, core_done,
    input  req_ready, core_start, owner, done_valid, busy, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/aes_core_arbiter.sv
// ----------------------------------------------------------------------------
// aes_core_arbiter : round-robin sharing of one AES core among N_REQ requesters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module aes_core_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 40,
  parameter int SEL_W   = $clog2(N_REQ)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  aes_core_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] c_last_rst = SEL_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_owner;
  logic [SEL_W-1:0] r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;

  logic             w_found;
  logic [SEL_W-1:0] w_win;
  logic             w_start;
  logic             w_resp;
  logic             w_to_hit;

  // Round-robin: first look above last_grant, then wrap to the bottom.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!w_found && bus.req_valid[j] && (j > int'(r_last_grant))) begin
        w_found = 1'b1;
        w_win   = SEL_W'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!w_found && bus.req_valid[j]) begin
        w_found = 1'b1;
        w_win   = SEL_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_resp      = 1'b0;
    w_to_hit    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_START;
      S_START: begin
        w_start     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      // core_done takes precedence over an expiring counter
      S_WAIT: begin
        if (bus.core_done) begin
          w_state_nxt = S_RESP;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = S_RESP;
          w_to_hit    = 1'b1;
        end
      end
      S_RESP: begin
        w_resp      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner       <= '0;
      r_last_grant  <= c_last_rst;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_found) r_owner <= w_win;
      if (w_resp) r_last_grant <= r_owner;
      if (w_start)                r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      if (w_to_hit) r_timeout_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_onehot
    assign bus.req_ready[g]  = w_start && (r_owner == SEL_W'(g));
    assign bus.done_valid[g] = w_resp  && (r_owner == SEL_W'(g));
  end

  assign bus.core_start  = w_start;
  assign bus.owner       = r_owner;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
// ----------------------------------------------------------------------------
// tb_aes_core_arbiter : table-driven, scoreboard-checked bench for aes_core_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_aes_core_arbiter;

  localparam int N_REQ   = 2;
  localparam int TIMEOUT = 40;

  // delay = WAIT cycles before core_done (core_done seen while counter == delay),
  // -1 means the core never answers
  typedef struct {
    logic [1:0] req;
    int         delay;
    int         own;
    logic       err;
  } vec_t;

  typedef struct {
    logic [1:0] dv;
    int         own;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   passed;
  exp_t sb[$];
  vec_t tbl[8];

  aes_core_arbiter_if #(.N_REQ(N_REQ)) bus ();

  aes_core_arbiter #(
    .N_REQ  (N_REQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_job(input vec_t v);
    bit         got;
    int         lat;
    exp_t       e;
    logic [1:0] oh;
    oh  = 2'(1 << v.own);
    got = 1'b0;
    lat = 0;
    bus.req_valid = v.req;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.core_start) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    if (!got) begin
      check("start_seen", 32'd0, 32'd1);
      bus.req_valid = '0;
      return;
    end
    check("start_latency", 32'(lat), 32'd1);
    check("req_ready", 32'(bus.req_ready), 32'(oh));
    check("owner_at_start", 32'(bus.owner), 32'(v.own));
    e.dv  = oh;
    e.own = v.own;
    sb.push_back(e);

    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= TIMEOUT + 8; k++) begin
      tick();
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.core_done = (v.delay >= 0) && (k == v.delay + 1);
      if (bus.done_valid != '0) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    bus.core_done = 1'b0;
    bus.req_valid = '0;
    e = sb.pop_front();
    if (!got) begin
      check("resp_seen", 32'd0, 32'd1);
      return;
    end
    check("done_valid", 32'(bus.done_valid), 32'(e.dv));
    check("owner_at_resp", 32'(bus.owner), 32'(e.own));
    check("resp_latency", 32'(lat), 32'((v.delay >= 0) ? v.delay + 2 : TIMEOUT + 1));
    check("timeout_err", 32'(bus.timeout_err), 32'(v.err));
    tick();
    check("busy_after_resp", 32'(bus.busy), 32'd0);
    check("pulses_after_resp", 32'({bus.req_ready, bus.core_start, bus.done_valid}), 32'd0);
  endtask

  initial begin
    tbl[0] = '{2'b01, 30, 0, 1'b0};   // single request, done 31 cycles after start
    tbl[1] = '{2'b11,  5, 1, 1'b0};
    tbl[2] = '{2'b11,  3, 0, 1'b0};
    tbl[3] = '{2'b11,  0, 1, 1'b0};
    tbl[4] = '{2'b10,  2, 1, 1'b0};
    tbl[5] = '{2'b01, 39, 0, 1'b0};   // done coincides with counter at TIMEOUT-1
    tbl[6] = '{2'b10, -1, 1, 1'b1};   // core never answers
    tbl[7] = '{2'b11,  4, 0, 1'b1};   // sticky error survives a normal job

    total  = 0;
    passed = 0;
    reset  = 1'b1;
    bus.req_valid = '0;
    bus.core_done = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_owner", 32'(bus.owner), 32'd0);
    check("rst_err", 32'(bus.timeout_err), 32'd0);
    check("rst_pulses", 32'({bus.req_ready, bus.core_start, bus.done_valid}), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_no_req", 32'({bus.busy, bus.req_ready, bus.core_start, bus.done_valid}), 32'd0);

    for (int i = 0; i < 8; i++) run_job(tbl[i]);

    // Abort mid-job: last grant was 0, so requester 1 wins here
    bus.req_valid = 2'b11;
    tick();
    check("abort_start", 32'({bus.core_start, bus.owner}), 32'b11);
    bus.req_valid = '0;
    repeat (3) tick();
    check("abort_in_wait", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_owner", 32'(bus.owner), 32'd0);
    check("abort_err", 32'(bus.timeout_err), 32'd0);
    check("abort_pulses", 32'({bus.req_ready, bus.core_start, bus.done_valid}), 32'd0);
    reset = 1'b0;

    // Late core_done lands in IDLE and must be ignored
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("spurious_idle", 32'({bus.busy, bus.timeout_err, bus.req_ready,
                                  bus.core_start, bus.done_valid}), 32'd0);
    end

    // Contention after reset: requester 0 first, then rotation
    run_job('{2'b11, 6, 0, 1'b0});
    run_job('{2'b11, 2, 1, 1'b0});
    run_job('{2'b11, 1, 0, 1'b0});

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, meaning number of requesters sharing one AES encryption core; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 40, meaning the maximum number of WAIT cycles allowed between core_start and core_done.
REQ-003 Parameter SEL_W, default $clog2(N_REQ), meaning the owner index width.
REQ-004 clk  in  1  rising-edge clock, single clock domain.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  N_REQ  per-requester encryption request; held high until the matching req_ready pulse.
REQ-007 req_ready  out  N_REQ  one-hot, single-cycle accept pulse to the granted requester.
REQ-008 core_start  out  1  single-cycle start pulse to the encryption core.
REQ-009 core_done  in  1  single-cycle completion pulse from the encryption core.
REQ-010 owner  out  SEL_W  index of the current grant holder; selects the key/data mux feeding the core.
REQ-011 done_valid  out  N_REQ  one-hot, single-cycle completion pulse to the owner.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 timeout_err  out  1  sticky flag; set when a job times out.

Function
REQ-014 The FSM SHALL have the states IDLE, START, WAIT and RESP, and SHALL be in exactly one of them each cycle.
REQ-015 IDLE: when any req_valid bit is high, the block SHALL pick a winner round-robin, searching from (last_grant+1) mod N_REQ upward.
REQ-016 IDLE: on a win, the block SHALL latch the winner into owner and go to START on the next cycle.
REQ-017 IDLE: with no req_valid bit high, the block SHALL stay in IDLE and all pulse outputs SHALL remain 0.
REQ-018 START lasts one cycle: req_ready[owner]=1 and core_start=1 in that cycle only, the WAIT counter is cleared, and the next state is WAIT.
REQ-019 WAIT: the counter SHALL increment each cycle; core_done=1 SHALL move the FSM to RESP.
REQ-020 WAIT: if the counter reaches TIMEOUT-1 with core_done=0, the FSM SHALL move to RESP and timeout_err SHALL be set to 1.
REQ-021 If core_done and the timeout condition coincide in the same cycle, core_done SHALL win and timeout_err SHALL stay unchanged.
REQ-022 RESP lasts one cycle: done_valid[owner]=1, last_grant is updated to owner, and the next state is IDLE.
REQ-023 A new arbitration SHALL NOT start in the RESP cycle, so each job has a minimum of one IDLE cycle between jobs.
REQ-024 Latency: req_valid high in IDLE at cycle 0 -> req_ready/core_start at cycle 1 -> core_done at cycle k -> done_valid at cycle k+1 -> IDLE at cycle k+2.
REQ-025 core_done arriving in IDLE, START or RESP SHALL be ignored: no state change and no flag change.
REQ-026 req_valid changes while in START, WAIT or RESP SHALL NOT affect owner or the state sequence.
REQ-027 owner SHALL be held constant from START through RESP inclusive.
REQ-028 The round-robin pointer SHALL wrap from N_REQ-1 to 0.
REQ-029 With all requesters continuously valid, grants SHALL rotate 0,1,...,N_REQ-1,0, and no requester SHALL wait for more than N_REQ jobs.
REQ-030 timeout_err SHALL be cleared only by reset.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL enter IDLE, with owner=0, counter=0, and req_ready, core_start, done_valid, busy and timeout_err all 0.
REQ-032 Reset SHALL set last_grant=N_REQ-1, so that requester 0 has first priority after reset.
REQ-033 Reset asserted mid-job (START/WAIT/RESP) SHALL abort the job with no done_valid pulse; a later core_done arriving in IDLE is ignored per REQ-025.

Verification
REQ-034 Single request: req_valid=01, core_done 31 cycles after core_start -> req_ready=01 and core_start at cycle 1, done_valid=01 at cycle 33, busy falls at cycle 34.
REQ-035 Contention: req_valid=11 held after reset -> grants to requester 0 then 1 then 0, owner=0/1/0, each done_valid one-hot to the matching owner.
REQ-036 Timeout: core_done never asserted -> after 40 WAIT cycles done_valid[owner]=1, timeout_err=1 and held until reset.
REQ-037 Coincidence: core_done on the same cycle as the counter reaching TIMEOUT-1 -> RESP entered, timeout_err=0.
REQ-038 Spurious/abort: core_done pulsed in IDLE -> no output change; reset during WAIT -> all outputs 0 next cycle, no done_valid, and requester 0 is granted first afterwards.
